// File: rtl/gpu_console_pkg.sv
// Shared definitions for the GPU text console writer: FSM state encoding,
// ASCII control codes and default screen geometry.
// GPU_TEXT_BUFFER_LENGTH is given a default here when the build does not
// supply it. It must equal COLUMNS*ROWS.
`ifndef GPU_TEXT_BUFFER_LENGTH
`define GPU_TEXT_BUFFER_LENGTH 2400
`endif

package gpu_console_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    SCROLL_READ  = 3'd1,
    SCROLL_WRITE = 3'd2,
    SCROLL_FILL  = 3'd3,
    CLEAR        = 3'd4,
    TAB          = 3'd5
  } state_t;

  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_TAB   = 8'h09;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  localparam int DEFAULT_COLUMNS = 80;
  localparam int DEFAULT_ROWS    = 30;

endpackage

// File: rtl/gpu_text_console_writer.sv
// Terminal-style writer feeding port A of the GPU text buffer RAM.
// Turns a character stream into cursor-addressed writes, handles LF/CR/BS,
// line wrap, scroll-by-one-row (copy via the registered RAM read port) and
// full-screen clear. Optional tab expansion is built when GPU_CONSOLE_TAB_EN
// is defined; otherwise 0x09 is stored like any printable code.
//
// Handshake: a character transfers on every rising edge where
// char_valid && char_ready. char_ready is high only in IDLE with no
// clear_request that cycle; char_in need not be held once transferred, and
// the producer may hold char_valid high across not-ready cycles.
module gpu_text_console_writer
  import gpu_console_pkg::*;
#(
  parameter int         COLUMNS    = DEFAULT_COLUMNS,
  parameter int         ROWS       = DEFAULT_ROWS,
  parameter logic [7:0] BLANK_CHAR = ASCII_SPACE
) (
  input  logic                                       CLOCK_50,
  input  logic                                       reset,
  input  logic [7:0]                                 char_in,
  input  logic                                       char_valid,
  output logic                                       char_ready,
  input  logic                                       clear_request,
  output logic [$clog2(`GPU_TEXT_BUFFER_LENGTH)-1:0] ram_address,
  output logic [7:0]                                 ram_write_data,
  output logic                                       ram_write_enable,
  input  logic [7:0]                                 ram_read_data,
  output logic [$clog2(ROWS)-1:0]                    cursor_row,
  output logic [$clog2(COLUMNS)-1:0]                 cursor_col,
  output logic                                       busy,
  output logic [2:0]                                 debug_state
);

  localparam int LENGTH = `GPU_TEXT_BUFFER_LENGTH;
  localparam int ADDR_W = $clog2(LENGTH);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int COL_W  = $clog2(COLUMNS);

  localparam logic [ADDR_W-1:0] ADDR_COLS  = ADDR_W'(COLUMNS);
  localparam logic [ADDR_W-1:0] LAST_SRC   = ADDR_W'((ROWS - 1) * COLUMNS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(LENGTH - 1);
  localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(COLUMNS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(ROWS - 1);

  state_t              state;
  logic [ADDR_W-1:0]   idx;
  logic [ADDR_W-1:0]   row_base;
  logic [ROW_W-1:0]    row;
  logic [COL_W-1:0]    col;

  logic                accept;
  logic                is_lf, is_cr, is_bs, is_tab, is_print;
  logic                col_at_end, row_at_end, in_tab, tab_stop;
  logic                line_step, col_inc;
  logic [ADDR_W-1:0]   cursor_addr;

  assign char_ready  = (state == IDLE) && !clear_request;
  assign accept      = char_valid && char_ready;
  assign busy        = (state != IDLE);
  assign cursor_row  = row;
  assign cursor_col  = col;
  assign debug_state = state;

  assign is_lf = (char_in == ASCII_LF);
  assign is_cr = (char_in == ASCII_CR);
  assign is_bs = (char_in == ASCII_BS);
`ifdef GPU_CONSOLE_TAB_EN
  assign is_tab = (char_in == ASCII_TAB);
`else
  assign is_tab = 1'b0;
`endif
  assign is_print = !(is_lf || is_cr || is_bs || is_tab);

  assign cursor_addr = row_base + ADDR_W'(col);
  assign col_at_end  = (col == LAST_COL);
  assign row_at_end  = (row == LAST_ROW);
  assign in_tab      = (state == TAB);
  // A tab stops once the column it is about to leave for is a multiple of 8
  // (a wrap to column 0 counts as a stop).
  assign tab_stop    = col_at_end || (col[2:0] == 3'b111);

  // Move to the start of the next row (LF, or wrap after the last column).
  assign line_step = (accept && (is_lf || (is_print && col_at_end))) ||
                     (in_tab && col_at_end);
  // Plain one-column advance after a written character or tab blank.
  assign col_inc   = (accept && is_print && !col_at_end) ||
                     (in_tab && !col_at_end);

  // RAM port A drive: write in the acceptance cycle for printable/BS,
  // otherwise addresses and data come from the state and the index counter.
  always_comb begin
    ram_address      = '0;
    ram_write_data   = '0;
    ram_write_enable = 1'b0;
    case (state)
      IDLE: begin
        ram_address = cursor_addr;
        if (accept && is_print) begin
          ram_write_enable = 1'b1;
          ram_write_data   = char_in;
        end else if (accept && is_bs && (col != '0)) begin
          ram_address      = cursor_addr - ADDR_W'(1);
          ram_write_enable = 1'b1;
          ram_write_data   = BLANK_CHAR;
        end
      end
      SCROLL_READ: ram_address = idx + ADDR_COLS;
      SCROLL_WRITE: begin
        ram_address      = idx;
        ram_write_data   = ram_read_data;
        ram_write_enable = 1'b1;
      end
      SCROLL_FILL, CLEAR: begin
        ram_address      = idx;
        ram_write_data   = BLANK_CHAR;
        ram_write_enable = 1'b1;
      end
`ifdef GPU_CONSOLE_TAB_EN
      TAB: begin
        ram_address      = cursor_addr;
        ram_write_data   = BLANK_CHAR;
        ram_write_enable = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // FSM, index counter and cursor registers; line_step comes last so that
  // reaching the bottom row overrides any earlier next-state choice.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      row_base <= '0;
      row      <= '0;
      col      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_request) begin
            state <= CLEAR;
            idx   <= '0;
          end else if (accept) begin
            if (is_cr) col <= '0;
            if (is_bs && (col != '0)) col <= col - COL_W'(1);
            if (is_tab) state <= TAB;
          end
        end
        SCROLL_READ: state <= SCROLL_WRITE;
        SCROLL_WRITE: begin
          idx   <= idx + ADDR_W'(1);
          state <= (idx == LAST_SRC) ? SCROLL_FILL : SCROLL_READ;
        end
        SCROLL_FILL: begin
          idx <= idx + ADDR_W'(1);
          if (idx == LAST_ADDR) state <= IDLE;
        end
        CLEAR: begin
          idx <= idx + ADDR_W'(1);
          if (idx == LAST_ADDR) begin
            state    <= IDLE;
            row      <= '0;
            col      <= '0;
            row_base <= '0;
          end
        end
`ifdef GPU_CONSOLE_TAB_EN
        TAB: if (tab_stop) state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
      if (col_inc) col <= col + COL_W'(1);
      if (line_step) begin
        col <= '0;
        if (row_at_end) begin
          state <= SCROLL_READ;
          idx   <= '0;
        end else begin
          row      <= row + ROW_W'(1);
          row_base <= row_base + ADDR_COLS;
        end
      end
    end
  end

endmodule

// File: tb/tb_gpu_text_console_writer.sv
// Self-checking bench for gpu_text_console_writer: table of single-character
// vectors plus hand-written sequences for line wrap, scroll, clear, reset
// during clear and (when GPU_CONSOLE_TAB_EN is defined) tab expansion.
`ifndef GPU_TEXT_BUFFER_LENGTH
`define GPU_TEXT_BUFFER_LENGTH 2400
`endif

module tb_gpu_text_console_writer;

  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int LEN    = `GPU_TEXT_BUFFER_LENGTH;
  localparam int ADDR_W = $clog2(LEN);
  localparam int SCROLL_CYCLES = 2 * (ROWS - 1) * COLS + COLS;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #10 clk = ~clk;

  logic [7:0]        char_in = '0;
  logic              char_valid = 1'b0;
  logic              char_ready;
  logic              clear_request = 1'b0;
  logic [ADDR_W-1:0] ram_address;
  logic [7:0]        ram_write_data;
  logic              ram_write_enable;
  logic [7:0]        ram_read_data;
  logic [4:0]        cursor_row;
  logic [6:0]        cursor_col;
  logic              busy;
  logic [2:0]        debug_state;

  gpu_text_console_writer dut (
    .CLOCK_50         (clk),
    .reset            (reset),
    .char_in          (char_in),
    .char_valid       (char_valid),
    .char_ready       (char_ready),
    .clear_request    (clear_request),
    .ram_address      (ram_address),
    .ram_write_data   (ram_write_data),
    .ram_write_enable (ram_write_enable),
    .ram_read_data    (ram_read_data),
    .cursor_row       (cursor_row),
    .cursor_col       (cursor_col),
    .busy             (busy),
    .debug_state      (debug_state)
  );

  function automatic logic [7:0] pat(input int k);
    return 8'((k * 7 + 3) % 256);
  endfunction

  // RAM model with registered read port and a one-cycle pattern preload
  logic [7:0] mem [LEN];
  logic       init_mem = 1'b0;
  always @(posedge clk) begin
    if (init_mem) begin
      for (int k = 0; k < LEN; k++) mem[k] <= pat(k);
    end else if (ram_write_enable) begin
      mem[ram_address] <= ram_write_data;
    end
    ram_read_data <= mem[ram_address];
  end

  // write monitor: every observed write as {address, data}
  logic [ADDR_W+7:0] got_q [$];
  logic [ADDR_W+7:0] exp_q [$];
  always @(negedge clk) begin
    if (ram_write_enable && !reset) got_q.push_back({ram_address, ram_write_data});
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // driver tasks: all start and end at posedge + 1
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    char_valid = 1'b0;
    clear_request = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic send(input logic [7:0] c, output logic w, output logic [ADDR_W-1:0] a,
                      output logic [7:0] d, output logic rdy);
    char_in = c;
    char_valid = 1'b1;
    @(negedge clk);
    w = ram_write_enable;
    a = ram_address;
    d = ram_write_data;
    rdy = char_ready;
    tick();
    char_valid = 1'b0;
  endtask

  task automatic load_pattern();
    init_mem = 1'b1;
    tick();
    init_mem = 1'b0;
  endtask

  // counts cycles with busy high, bounded; also counts cycles with char_ready high
  task automatic wait_idle(input int limit, output int n, output int rdy_hi);
    int guard;
    n = 0;
    rdy_hi = 0;
    guard = 0;
    @(negedge clk);
    while (busy && guard < limit) begin
      n++;
      if (char_ready) rdy_hi++;
      @(negedge clk);
      guard++;
    end
    tick();
  endtask

  // compares exp_q against monitor entries starting at index base
  task automatic compare_writes(input string name, input int base);
    int errs;
    errs = 0;
    check({name, "_count"}, got_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i >= got_q.size()) errs++;
      else if (got_q[base + i] !== exp_q[i]) errs++;
    end
    check({name, "_content_errs"}, errs, 0);
  endtask

  typedef struct {
    logic [7:0]        c;
    logic              exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic [7:0]        exp_data;
    logic [4:0]        exp_row;
    logic [6:0]        exp_col;
  } vec_t;

  vec_t vecs [$];

  initial begin
    logic              w, rdy;
    logic [ADDR_W-1:0] a;
    logic [7:0]        d;
    int                n, rdy_hi, base, errs;
    logic [7:0]        hello [5];
    logic [7:0]        old_v, exp_v;

    // vectors applied in order from a freshly reset cursor (0,0)
    vecs.push_back('{8'h41, 1'b1, ADDR_W'(0),   8'h41, 5'd0, 7'd1});
    vecs.push_back('{8'h42, 1'b1, ADDR_W'(1),   8'h42, 5'd0, 7'd2});
    vecs.push_back('{8'h0D, 1'b0, ADDR_W'(0),   8'h00, 5'd0, 7'd0});
    vecs.push_back('{8'h0A, 1'b0, ADDR_W'(0),   8'h00, 5'd1, 7'd0});
    vecs.push_back('{8'h78, 1'b1, ADDR_W'(80),  8'h78, 5'd1, 7'd1});
    vecs.push_back('{8'h08, 1'b1, ADDR_W'(80),  8'h20, 5'd1, 7'd0});
    vecs.push_back('{8'h08, 1'b0, ADDR_W'(0),   8'h00, 5'd1, 7'd0});
    vecs.push_back('{8'h0A, 1'b0, ADDR_W'(0),   8'h00, 5'd2, 7'd0});
    vecs.push_back('{8'h0A, 1'b0, ADDR_W'(0),   8'h00, 5'd3, 7'd0});
    vecs.push_back('{8'h08, 1'b0, ADDR_W'(0),   8'h00, 5'd3, 7'd0});
    vecs.push_back('{8'h31, 1'b1, ADDR_W'(240), 8'h31, 5'd3, 7'd1});
    vecs.push_back('{8'h32, 1'b1, ADDR_W'(241), 8'h32, 5'd3, 7'd2});
    vecs.push_back('{8'h33, 1'b1, ADDR_W'(242), 8'h33, 5'd3, 7'd3});
    vecs.push_back('{8'h34, 1'b1, ADDR_W'(243), 8'h34, 5'd3, 7'd4});
    vecs.push_back('{8'h08, 1'b1, ADDR_W'(243), 8'h20, 5'd3, 7'd3});
`ifndef GPU_CONSOLE_TAB_EN
    vecs.push_back('{8'h09, 1'b1, ADDR_W'(243), 8'h09, 5'd3, 7'd4});
`endif

    // reset state
    do_reset();
    @(negedge clk);
    check("rst_we", ram_write_enable, 0);
    check("rst_addr", ram_address, 0);
    check("rst_data", ram_write_data, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", char_ready, 1);
    check("rst_row", cursor_row, 0);
    check("rst_col", cursor_col, 0);
    tick();

    // table-driven single characters
    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].c, w, a, d, rdy);
      check($sformatf("vec%0d_ready", i), rdy, 1);
      check($sformatf("vec%0d_we", i), w, vecs[i].exp_we);
      if (vecs[i].exp_we) begin
        check($sformatf("vec%0d_addr", i), a, vecs[i].exp_addr);
        check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
      end
      check($sformatf("vec%0d_row", i), cursor_row, vecs[i].exp_row);
      check($sformatf("vec%0d_col", i), cursor_col, vecs[i].exp_col);
    end

    // one full row of printable characters wraps to (1,0) without a scroll
    do_reset();
    base = got_q.size();
    exp_q.delete();
    for (int i = 0; i < COLS; i++) begin
      send(8'h61 + 8'(i % 26), w, a, d, rdy);
      exp_q.push_back({ADDR_W'(i), 8'h61 + 8'(i % 26)});
    end
    compare_writes("row_fill", base);
    check("row_fill_last_addr", got_q[got_q.size() - 1][ADDR_W+7:8], 79);
    check("row_fill_row", cursor_row, 1);
    check("row_fill_col", cursor_col, 0);
    check("row_fill_busy", busy, 0);

    // scroll: preload pattern, move to (29,5), then LF
    do_reset();
    load_pattern();
    for (int i = 0; i < ROWS - 1; i++) send(8'h0A, w, a, d, rdy);
    check("pre_scroll_row", cursor_row, 29);
    hello[0] = 8'h48; hello[1] = 8'h45; hello[2] = 8'h4C; hello[3] = 8'h4C; hello[4] = 8'h4F;
    for (int i = 0; i < 5; i++) send(hello[i], w, a, d, rdy);
    check("pre_scroll_col", cursor_col, 5);
    base = got_q.size();
    send(8'h0A, w, a, d, rdy);
    check("scroll_lf_we", w, 0);
    @(negedge clk);
    check("scroll_mid_row", cursor_row, 29);
    check("scroll_mid_col", cursor_col, 0);
    check("scroll_mid_busy", busy, 1);
    tick();
    wait_idle(10000, n, rdy_hi);
    check("scroll_busy_cycles", n + 1, SCROLL_CYCLES);
    check("scroll_ready_high_cycles", rdy_hi, 0);
    check("scroll_write_count", got_q.size() - base, LEN);
    errs = 0;
    for (int k = 0; k < LEN; k++) begin
      if (k < (ROWS - 1) * COLS) begin
        if (k + COLS >= (ROWS - 1) * COLS && k + COLS < (ROWS - 1) * COLS + 5)
          old_v = hello[k + COLS - (ROWS - 1) * COLS];
        else
          old_v = pat(k + COLS);
        exp_v = old_v;
      end else begin
        exp_v = 8'h20;
      end
      if (mem[k] !== exp_v) errs++;
    end
    check("scroll_mem_errs", errs, 0);
    check("scroll_end_row", cursor_row, 29);
    check("scroll_end_col", cursor_col, 0);

    // clear_request wins over a simultaneous character
    base = got_q.size();
    char_in = 8'h5A;
    char_valid = 1'b1;
    clear_request = 1'b1;
    @(negedge clk);
    check("clr_ready", char_ready, 0);
    check("clr_first_we", ram_write_enable, 0);
    tick();
    char_valid = 1'b0;
    clear_request = 1'b0;
    wait_idle(5000, n, rdy_hi);
    check("clr_busy_cycles", n, LEN);
    check("clr_ready_high_cycles", rdy_hi, 0);
    check("clr_write_count", got_q.size() - base, LEN);
    errs = 0;
    for (int k = 0; k < LEN; k++) if (mem[k] !== 8'h20) errs++;
    check("clr_mem_errs", errs, 0);
    check("clr_row", cursor_row, 0);
    check("clr_col", cursor_col, 0);

    // reset during clear aborts at once, leaving the buffer partial
    load_pattern();
    clear_request = 1'b1;
    tick();
    clear_request = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) n++;
      if (i < 99) tick();
    end
    check("clr_abort_busy_before", n, 100);
    reset = 1'b1;
    tick();
    check("clr_abort_we", ram_write_enable, 0);
    check("clr_abort_busy", busy, 0);
    check("clr_abort_state", debug_state, 0);
    check("clr_abort_mem99", mem[99], 8'h20);
    check("clr_abort_mem100", mem[100], pat(100));
    check("clr_abort_mem_last", mem[LEN - 1], pat(LEN - 1));
    reset = 1'b0;
    tick();

`ifdef GPU_CONSOLE_TAB_EN
    // tab from (0,3) pads with blanks up to column 8
    do_reset();
    for (int i = 0; i < 3; i++) send(8'h61, w, a, d, rdy);
    base = got_q.size();
    send(8'h09, w, a, d, rdy);
    check("tab_accept_we", w, 0);
    wait_idle(100, n, rdy_hi);
    check("tab_ready_high_cycles", rdy_hi, 0);
    exp_q.delete();
    for (int i = 3; i < 8; i++) exp_q.push_back({ADDR_W'(i), 8'h20});
    compare_writes("tab", base);
    check("tab_row", cursor_row, 0);
    check("tab_col", cursor_col, 8);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // overall time bound
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
